// File: rtl/rx_data_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rx_data_buffer
// Purpose  : Byte FIFO behind the receive controller. Each entry holds a
//            payload byte plus its end-of-frame tag. The consumer side is a
//            first-word-fall-through AXI-Stream style master. The block also
//            keeps a count of stored bytes and of complete frames buffered.
// Revision : 1.0 - initial release
// ============================================================================
module rx_data_buffer #(
  parameter  int DEPTH       = 16,
  parameter  int AFULL_LEVEL = 12,
  localparam int LW          = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  input  logic          wr_last,
  output logic          full,
  output logic          almost_full,
  output logic          m_valid,
  output logic [7:0]    m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic [LW-1:0] level,
  output logic [LW-1:0] frame_cnt,
  output logic          frame_avail
);

  localparam int AW = LW - 1;

  // Storage: bit 8 is the end-of-frame tag, bits 7:0 the payload byte.
  logic [8:0]    r_mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [LW-1:0] r_wr_ptr;
  logic [LW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] r_frame_cnt;

  logic          w_empty;
  logic          w_full;
  logic          w_wr_en;
  logic          w_rd_en;
  logic [8:0]    w_head;
  logic          w_fr_inc;
  logic          w_fr_dec;

  // Full/empty come only from registered pointers, so there is no path
  // from wr_valid or m_ready into full (keeps the controller's ready loop open).
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign w_wr_en  = wr_valid & ~w_full;
  assign w_rd_en  = ~w_empty & m_ready;
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
  assign w_fr_inc = w_wr_en & wr_last;
  assign w_fr_dec = w_rd_en & w_head[8];

  // Data store: written only on an accepted byte outside reset/flush.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {wr_last, wr_data};
    end
  end

  // Pointer and occupancy bookkeeping; reset beats flush, flush beats traffic.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + LW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + LW'(1);

      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      case ({w_fr_inc, w_fr_dec})
        2'b10:   r_frame_cnt <= r_frame_cnt + LW'(1);
        2'b01:   r_frame_cnt <= r_frame_cnt - LW'(1);
        default: r_frame_cnt <= r_frame_cnt;
      endcase
    end
  end

  assign full        = w_full;
  assign almost_full = (r_level >= LW'(AFULL_LEVEL));
  assign m_valid     = ~w_empty;
  assign m_data      = w_head[7:0];
  assign m_last      = w_head[8];
  assign level       = r_level;
  assign frame_cnt   = r_frame_cnt;
  assign frame_avail = (r_frame_cnt != '0);

endmodule
`default_nettype wire
